// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - board cell encoding and RAM geometry shared by board-state writers
package board_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_t;

  localparam int BOARD_CELLS  = 100;
  localparam int BOARD_ADDR_W = 7;
  localparam int BOARD_DATA_W = 2;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin select: first set request scanning cyclically from ptr
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      cand[k] = PW'((int'(ptr) + k) % N);
    end
  end

  // Scan from the far end so the candidate closest to ptr is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/vblank_ram_arbiter.sv
// rtl/vblank_ram_arbiter.sv - round-robin, burst-bounded sharing of the board RAM write port during vblank
module vblank_ram_arbiter
  import board_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = BOARD_ADDR_W,
  parameter int DATA_W    = BOARD_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vblnk,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        wr_valid,
  input  logic [N_REQ-1:0]        wr_last,
  input  logic [N_REQ*ADDR_W-1:0] wr_addr,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        wr_ready,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  output logic                    frame_start,
  output logic [7:0]              miss_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    WAIT_VB = 2'd0,
    ARB     = 2'd1,
    BURST   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             vblnk_d;
  logic [PW-1:0]    rr_ptr, rr_ptr_n;
  logic [PW-1:0]    gidx, gidx_n;
  logic [BW-1:0]    beat_cnt, beat_cnt_n;
  logic [N_REQ-1:0] gnt_n;

  logic [N_REQ-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  logic window_open, window_close, accept, beat_last, burst_end;
  logic [PW-1:0] ptr_after;

  rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign window_open  = vblnk & ~vblnk_d;
  assign window_close = ~vblnk & vblnk_d;

  // Ready is gated by the live vblnk so a beat offered as the window closes is never taken.
  assign wr_ready  = gnt & {N_REQ{vblnk}};
  assign accept    = |(wr_valid & wr_ready);
  assign beat_last = wr_last[gidx] | (beat_cnt == BW'(MAX_BURST - 1));
  assign burst_end = ~vblnk | (accept & beat_last) | (~accept & ~req[gidx]);
  assign ptr_after = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    gidx_n     = gidx;
    beat_cnt_n = beat_cnt;
    rr_ptr_n   = rr_ptr;
    case (state)
      WAIT_VB: begin
        if (window_open) state_n = ARB;
      end
      ARB: begin
        if (!vblnk) begin
          state_n = WAIT_VB;
        end else if (pick_any) begin
          gnt_n      = pick_onehot;
          gidx_n     = pick_idx;
          beat_cnt_n = '0;
          state_n    = BURST;
        end
      end
      BURST: begin
        if (burst_end) begin
          gnt_n    = '0;
          rr_ptr_n = ptr_after;
          state_n  = vblnk ? ARB : WAIT_VB;
        end else if (accept) begin
          beat_cnt_n = beat_cnt + 1'b1;
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = WAIT_VB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_VB;
      vblnk_d     <= 1'b1;
      rr_ptr      <= '0;
      gidx        <= '0;
      beat_cnt    <= '0;
      gnt         <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      frame_start <= 1'b0;
      miss_cnt    <= '0;
    end else begin
      state       <= state_n;
      vblnk_d     <= vblnk;
      rr_ptr      <= rr_ptr_n;
      gidx        <= gidx_n;
      beat_cnt    <= beat_cnt_n;
      gnt         <= gnt_n;
      frame_start <= window_open;
      ram_we      <= accept;
      if (accept) begin
        ram_addr  <= wr_addr[gidx*ADDR_W +: ADDR_W];
        ram_wdata <= wr_data[gidx*DATA_W +: DATA_W];
      end
      if (window_close && (|req) && (miss_cnt != 8'hFF)) begin
        miss_cnt <= miss_cnt + 8'd1;
      end
    end
  end

endmodule
